// File: rtl/react_pkg.sv
// Shared types and constants for the reaction-time tester core.
package react_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, RUN, DONE, EARLY} state_t;

   localparam logic [15:0] EARLY_CODE = 16'hEEEE;
   localparam logic [15:0] BCD_MAX    = 16'h9999;
   // Taps 16,14,13,11 with stage 16 at bit 0: feedback from bits 0,2,3,5, shifting right.
   localparam logic [15:0] LFSR_TAPS  = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/react_timer_bcd4_counter.sv
// Four-digit BCD up-counter that saturates at 9999.
module bcd4_counter
   import react_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] q,
   output logic        at_max
);

   logic [15:0] q_inc;
   logic        carry;

   assign at_max = (q == BCD_MAX);

   always_comb begin
      q_inc = q;
      carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (carry) begin
            if (q[4*i +: 4] == 4'd9) begin
               q_inc[4*i +: 4] = 4'd0;
            end else begin
               q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
               carry           = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !at_max) begin
         q <= q_inc;
      end
   end

endmodule

// File: rtl/react_timer.sv
// Reaction-time tester: random foreperiod, stimulus LED, millisecond count to stop press.
module react_timer
   import react_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned RAND_BITS    = 11,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_btn,
   input  logic        stop_btn,
   output logic        led,
   output logic        busy,
   output logic        early,
   output logic [15:0] dat
);

   localparam int unsigned MS_DIV = CLK_HZ / 1000;
   localparam int unsigned PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int unsigned DW     = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);

   state_t        state, state_next;
   logic [2:0]    start_sync, stop_sync;
   logic          start_p, stop_p;
   logic [15:0]   lfsr;
   logic [PW-1:0] presc;
   logic          tick;
   logic [DW-1:0] delay, delay_next;
   logic          cnt_clr, cnt_inc, cnt_max;
   logic [15:0]   cnt_q;

   assign tick = (presc == PW'(MS_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      delay_next = delay;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE, DONE, EARLY: begin
            if (start_p) begin
               state_next = WAIT;
               delay_next = DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
               cnt_clr    = 1'b1;
            end
         end
         WAIT: begin
            if (stop_p) begin
               state_next = EARLY;
            end else if (tick) begin
               if (delay <= DW'(1)) state_next = RUN;
               else                 delay_next = delay - DW'(1);
            end
         end
         RUN: begin
            // Stop beats a coincident tick, so the final count is never bumped on the stop edge.
            if (stop_p || cnt_max) state_next = DONE;
            else if (tick)         cnt_inc    = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_sync <= '0;
         stop_sync  <= '0;
         start_p    <= 1'b0;
         stop_p     <= 1'b0;
         lfsr       <= LFSR_SEED;
         presc      <= '0;
         delay      <= '0;
         led        <= 1'b0;
         busy       <= 1'b0;
         early      <= 1'b0;
      end else begin
         start_sync <= {start_sync[1:0], start_btn};
         stop_sync  <= {stop_sync[1:0], stop_btn};
         start_p    <= start_sync[1] & ~start_sync[2];
         stop_p     <= stop_sync[1] & ~stop_sync[2];
         lfsr       <= lfsr_next(lfsr);
         presc      <= (tick || state_next != state) ? '0 : presc + PW'(1);
         delay      <= delay_next;
         led        <= (state_next == RUN);
         busy       <= (state_next == WAIT) || (state_next == RUN);
         early      <= (state_next == EARLY);
      end
   end

   bcd4_counter u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .q      (cnt_q),
      .at_max (cnt_max)
   );

   always_comb begin
      dat = early ? EARLY_CODE : cnt_q;
   end

endmodule

// File: tb/tb_react_timer.sv
// Self-checking bench for react_timer against a cycle-level behavioural model.
module tb_react_timer;

   localparam int CLK_HZ = 2000;
   localparam int MS_DIV = CLK_HZ / 1000;
   localparam int MIN_MS = 5;
   localparam int RB     = 2;

   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_RUN   = 2;
   localparam int M_DONE  = 3;
   localparam int M_EARLY = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_btn = 1'b0;
   logic        stop_btn = 1'b0;
   logic        led, busy, early;
   logic [15:0] dat;

   react_timer #(
      .CLK_HZ       (CLK_HZ),
      .MIN_DELAY_MS (MIN_MS),
      .RAND_BITS    (RB),
      .LFSR_SEED    (16'hACE1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_btn (start_btn),
      .stop_btn  (stop_btn),
      .led       (led),
      .busy      (busy),
      .early     (early),
      .dat       (dat)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   int          m_mode = M_IDLE;
   int          m_ms_left = 0;
   int          m_count = 0;
   int          m_cis = 0;
   int          m_load = 0;
   int          m_prev;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [3:0]  hs = '0, hp = '0;
   logic        m_sp, m_tp, m_tick;

   function automatic logic [15:0] lstep(input logic [15:0] l);
      logic fb;
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      return (l >> 1) | ({15'd0, fb} << 15);
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   // Ticks that land on the next three edges given the time spent in the current state.
   function automatic int ahead(input int cis);
      int t = 0;
      for (int k = 1; k <= 3; k++)
         if (((cis + k - 1) % MS_DIV) == MS_DIV - 1) t++;
      return t;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = M_IDLE; m_ms_left = 0; m_count = 0; m_cis = 0;
         m_lfsr = 16'hACE1; hs = '0; hp = '0;
      end else begin
         m_sp   = hs[2] & ~hs[3];
         m_tp   = hp[2] & ~hp[3];
         hs     = {hs[2:0], start_btn};
         hp     = {hp[2:0], stop_btn};
         m_tick = (m_cis % MS_DIV) == MS_DIV - 1;
         m_prev = m_mode;
         case (m_mode)
            M_WAIT: begin
               if (m_tp) m_mode = M_EARLY;
               else if (m_tick) begin
                  m_ms_left--;
                  if (m_ms_left == 0) m_mode = M_RUN;
               end
            end
            M_RUN: begin
               if (m_tp || m_count == 9999) m_mode = M_DONE;
               else if (m_tick) m_count++;
            end
            default: begin
               if (m_sp) begin
                  m_mode    = M_WAIT;
                  m_load    = MIN_MS + (int'(m_lfsr) % (1 << RB));
                  m_ms_left = m_load;
                  m_count   = 0;
               end
            end
         endcase
         m_lfsr = lstep(m_lfsr);
         m_cis  = (m_mode != m_prev) ? 0 : m_cis + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_and_measure(output int lat);
      lat = 0;
      start_btn = 1'b1;
      while (!led && lat < 400) begin
         step(1);
         lat++;
         if (lat == 2) start_btn = 1'b0;
      end
      start_btn = 1'b0;
      chk("led_rise_timeout", led, 1);
   endtask

   task automatic stop_at(input int target, input bit coincide);
      int n = 0;
      while (n < 40000 && !(m_mode == M_RUN && m_count + ahead(m_cis) == target &&
             (!coincide || ((m_cis + 3) % MS_DIV) == MS_DIV - 1))) begin
         step(1);
         n++;
      end
      chk("stop_window_timeout", (n < 40000), 1);
      stop_btn = 1'b1;
      step(3);
      stop_btn = 1'b0;
      step(2);
   endtask

   initial begin
      int lat1, lat2, n;
      logic [15:0] prev;
      fork
         begin
            while (!done) begin
               @(negedge clk);
               if (!done) begin
                  chk("led", led, (m_mode == M_RUN));
                  chk("busy", busy, (m_mode == M_WAIT || m_mode == M_RUN));
                  chk("early", early, (m_mode == M_EARLY));
                  chk("dat", dat, (m_mode == M_EARLY) ? 16'hEEEE : to_bcd(m_count));
               end
            end
         end
         begin
            chk("pin_lfsr1", lstep(16'hACE1), 16'h5670);
            chk("pin_lfsr2", lstep(16'h5670), 16'hAB38);
            chk("pin_bcd", to_bcd(4097), 16'h4097);
            step(5);
            chk("rst_led", led, 0);
            chk("rst_busy", busy, 0);
            chk("rst_early", early, 0);
            chk("rst_dat", dat, 16'h0000);
            rst = 1'b0;
            step(3);

            start_and_measure(lat1);
            chk("load_range", (m_load >= MIN_MS && m_load <= MIN_MS + 3), 1);
            chk("led_latency", lat1, 4 + m_load * MS_DIV);
            stop_at(237, 1'b0);
            chk("stop237_dat", dat, 16'h0237);
            chk("stop237_led", led, 0);
            chk("stop237_busy", busy, 0);
            step(1000);
            chk("hold237_dat", dat, 16'h0237);

            start_btn = 1'b1; step(2); start_btn = 1'b0;
            n = 0;
            while (!busy && n < 20) begin step(1); n++; end
            chk("early_busy_timeout", busy, 1);
            step(2);
            stop_btn = 1'b1; step(2); stop_btn = 1'b0;
            step(3);
            chk("early_flag", early, 1);
            chk("early_dat", dat, 16'hEEEE);
            chk("early_led", led, 0);
            start_btn = 1'b1; step(2); start_btn = 1'b0;
            step(3);
            chk("restart_early", early, 0);
            chk("restart_dat", dat, 16'h0000);
            chk("restart_busy", busy, 1);

            n = 0;
            while (!led && n < 100) begin step(1); n++; end
            chk("run41_led_timeout", led, 1);
            step(3);
            start_btn = 1'b1; step(2); start_btn = 1'b0;
            step(4);
            chk("start_in_run_led", led, 1);
            stop_at(41, 1'b1);
            chk("coincide_dat", dat, 16'h0041);

            start_and_measure(n);
            prev = dat;
            n = 0;
            while (busy && n < 25000) begin
               step(1);
               n++;
               if (dat != prev) begin
                  if (prev == 16'h0009) chk("carry_0010", dat, 16'h0010);
                  if (prev == 16'h0099) chk("carry_0100", dat, 16'h0100);
                  if (prev == 16'h0999) chk("carry_1000", dat, 16'h1000);
                  prev = dat;
               end
            end
            chk("sat_timeout", busy, 0);
            chk("sat_dat", dat, 16'h9999);
            step(50);
            chk("sat_hold", dat, 16'h9999);
            chk("sat_led", led, 0);

            start_and_measure(n);
            n = 0;
            while (!(m_mode == M_RUN && m_count == 123) && n < 2000) begin step(1); n++; end
            chk("run123_reach", dat, 16'h0123);
            #2 rst = 1'b1;
            #1;
            chk("async_rst_dat", dat, 16'h0000);
            chk("async_rst_led", led, 0);
            chk("async_rst_busy", busy, 0);
            @(posedge clk);
            #1 rst = 1'b0;
            step(3);
            start_and_measure(lat2);
            chk("reseed_latency", lat2, lat1);
            stop_at(3, 1'b0);

            for (int i = 0; i < 60; i++) begin
               int r;
               r = int'($urandom_range(0, 3));
               start_btn = (r == 0 || r == 2);
               stop_btn  = (r == 1 || r == 2);
               step(int'($urandom_range(1, 4)));
               start_btn = 1'b0;
               stop_btn  = 1'b0;
               step(int'($urandom_range(2, 60)));
            end
            step(5);
            done = 1'b1;
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
